// File: rtl/sm83_mem_bridge.sv
// sm83_mem_bridge: resynchronises SM83 bus strobes into CLK and turns them into req/ack memory transactions with a boot-ROM overlay
module sm83_mem_bridge #(
   parameter int          SYNC_STAGES = 2,
   parameter int          BOOT_SIZE   = 256,
   parameter logic [15:0] BOOT_REG    = 16'hFF50
) (
   input  logic                         CLK,
   input  logic                         nRESET,
   input  logic [15:0]                  A,
   input  logic [7:0]                   D_IN,
   output logic [7:0]                   D_OUT,
   output logic                         D_OE,
   input  logic                         RD,
   input  logic                         WR,
   input  logic                         MREQ,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [15:0]                  mem_addr,
   output logic [7:0]                   mem_wdata,
   input  logic                         mem_ack,
   input  logic [7:0]                   mem_rdata,
   output logic [$clog2(BOOT_SIZE)-1:0] boot_addr,
   input  logic [7:0]                   boot_data,
   output logic                         boot_en,
   output logic                         overrun
);
   localparam int BW = $clog2(BOOT_SIZE);
   localparam logic [16:0] BOOT_LIM = 17'(BOOT_SIZE);
   typedef enum logic [2:0] {IDLE, RD_BOOT, RD_MEM, RD_HOLD, WR_MEM} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] rd_sync, wr_sync, mreq_sync;
   logic [15:0] a_pipe [SYNC_STAGES+1];
   logic [7:0] d_pipe [SYNC_STAGES+1];
   logic rd_d, wr_d;
   logic [7:0] d_out_n, wdata_n;
   logic [15:0] addr_n;
   logic d_oe_n, req_n, we_n, boot_en_n, overrun_n;
   wire rd_s = rd_sync[SYNC_STAGES-1] & mreq_sync[SYNC_STAGES-1];
   wire wr_s = wr_sync[SYNC_STAGES-1];
   wire rd_rise = rd_s & ~rd_d;
   wire wr_fall = ~wr_s & wr_d;
   wire [15:0] a_q = a_pipe[0];
   // the last pipeline stage holds A/D as they stood the cycle before WR was first sampled low
   wire [15:0] wa = a_pipe[SYNC_STAGES];
   wire [7:0] wd = d_pipe[SYNC_STAGES];
   wire is_boot = boot_en && ({1'b0, a_q} < BOOT_LIM);
   assign boot_addr = (state == IDLE) ? a_q[BW-1:0] : mem_addr[BW-1:0];
   // strobe synchronisers
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         rd_sync   <= '0;
         wr_sync   <= '0;
         mreq_sync <= '0;
      end else begin
         rd_sync   <= {rd_sync[SYNC_STAGES-2:0], RD};
         wr_sync   <= {wr_sync[SYNC_STAGES-2:0], WR};
         mreq_sync <= {mreq_sync[SYNC_STAGES-2:0], MREQ};
      end
   end
   // address/data delay line aligned with the strobe synchronisers
   always_ff @(posedge CLK) begin
      a_pipe[0] <= A;
      d_pipe[0] <= D_IN;
      for (int i = 1; i <= SYNC_STAGES; i++) begin
         a_pipe[i] <= a_pipe[i-1];
         d_pipe[i] <= d_pipe[i-1];
      end
   end
   // state and registered bus outputs
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state     <= IDLE;
         D_OUT     <= '0;
         D_OE      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         boot_en   <= 1'b1;
         overrun   <= 1'b0;
         rd_d      <= 1'b0;
         wr_d      <= 1'b0;
      end else begin
         state     <= state_n;
         D_OUT     <= d_out_n;
         D_OE      <= d_oe_n;
         mem_req   <= req_n;
         mem_we    <= we_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         boot_en   <= boot_en_n;
         overrun   <= overrun_n;
         rd_d      <= rd_s;
         wr_d      <= wr_s;
      end
   end
   // next-state and output logic; a write edge wins over a simultaneous read edge
   always_comb begin
      state_n   = state;
      d_out_n   = D_OUT;
      d_oe_n    = D_OE;
      req_n     = mem_req;
      we_n      = mem_we;
      addr_n    = mem_addr;
      wdata_n   = mem_wdata;
      boot_en_n = boot_en;
      overrun_n = overrun | ((rd_rise | wr_fall) & ((state != IDLE) | (rd_rise & wr_fall)));
      case (state)
         IDLE: begin
            if (wr_fall) begin
               state_n = WR_MEM;
               req_n   = 1'b1;
               we_n    = 1'b1;
               addr_n  = wa;
               wdata_n = wd;
               if (wa == BOOT_REG && wd != '0) boot_en_n = 1'b0;
            end else if (rd_rise) begin
               addr_n  = a_q;
               we_n    = 1'b0;
               state_n = is_boot ? RD_BOOT : RD_MEM;
               req_n   = ~is_boot;
            end
         end
         RD_BOOT: begin
            state_n = RD_HOLD;
            d_out_n = boot_data;
            d_oe_n  = 1'b1;
         end
         RD_MEM: begin
            if (mem_ack) begin
               state_n = RD_HOLD;
               req_n   = 1'b0;
               d_out_n = mem_rdata;
               d_oe_n  = 1'b1;
            end
         end
         RD_HOLD: begin
            if (!rd_s) begin
               state_n = IDLE;
               d_oe_n  = 1'b0;
            end
         end
         WR_MEM: begin
            if (mem_ack) begin
               state_n = IDLE;
               req_n   = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_sm83_mem_bridge.sv
// tb_sm83_mem_bridge: randomized transaction-level checks of sm83_mem_bridge against a bus-level reference model
module tb_sm83_mem_bridge;
   logic CLK = 1'b0, nRESET = 1'b0;
   logic [15:0] A = '0;
   logic [7:0] D_IN = '0, mem_rdata = '0, boot_data = '0;
   logic RD = 1'b0, WR = 1'b0, MREQ = 1'b0, mem_ack = 1'b0;
   logic [7:0] D_OUT, mem_wdata, boot_addr;
   logic D_OE, mem_req, mem_we, boot_en, overrun;
   logic [15:0] mem_addr;
   logic [7:0] rom [256];
   int errs = 0, checks = 0, req_cnt = 0;
   logic req_prev = 1'b0;
   bit boot_m = 1'b1;

   sm83_mem_bridge dut (
      .CLK(CLK), .nRESET(nRESET), .A(A), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
      .RD(RD), .WR(WR), .MREQ(MREQ), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .boot_addr(boot_addr), .boot_data(boot_data), .boot_en(boot_en), .overrun(overrun)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) boot_data <= rom[boot_addr];
   always @(negedge CLK) begin
      if (mem_req && !req_prev) req_cnt++;
      req_prev = mem_req;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge CLK);
   endtask

   task automatic do_reset();
      nRESET = 1'b0; RD = 1'b0; WR = 1'b0; MREQ = 1'b0; mem_ack = 1'b0;
      tick(2);
      nRESET = 1'b1;
      boot_m = 1'b1;
      tick(3);
   endtask

   task automatic test_reset();
      A = 16'h1234; D_IN = 8'h55;
      do_reset();
      checks++; if (D_OE !== 1'b0 || D_OUT !== 8'h00) begin errs++; $display("FAIL reset_d: D_OE=%b D_OUT=%h want 0/00", D_OE, D_OUT); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errs++; $display("FAIL reset_req: req=%b we=%b want 0/0", mem_req, mem_we); end
      checks++; if (mem_addr !== 16'h0 || mem_wdata !== 8'h0) begin errs++; $display("FAIL reset_bus: addr=%h wdata=%h want 0000/00", mem_addr, mem_wdata); end
      checks++; if (boot_en !== 1'b1 || overrun !== 1'b0) begin errs++; $display("FAIL reset_flags: boot_en=%b overrun=%b want 1/0", boot_en, overrun); end
   endtask

   task automatic test_read(input logic [15:0] addr, input int lat);
      int r0;
      bit boot;
      logic [7:0] rdat, exp;
      r0 = req_cnt;
      boot = boot_m && addr < 16'h0100;
      rdat = 8'($urandom);
      exp = boot ? rom[addr[7:0]] : rdat;
      A = addr; MREQ = 1'b1; RD = 1'b1;
      tick();
      if (!boot) begin
         for (int i = 0; i < 10 && mem_req !== 1'b1; i++) tick();
         checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== addr) begin errs++; $display("FAIL rd_req: req=%b we=%b addr=%h want 1/0/%h", mem_req, mem_we, mem_addr, addr); end
         for (int i = 0; i < lat; i++) begin
            tick();
            checks++; if (mem_req !== 1'b1 || D_OE !== 1'b0 || mem_addr !== addr) begin errs++; $display("FAIL rd_wait: req=%b D_OE=%b addr=%h want 1/0/%h", mem_req, D_OE, mem_addr, addr); end
         end
         mem_ack = 1'b1; mem_rdata = rdat;
         tick();
         mem_ack = 1'b0; mem_rdata = ~rdat;
         checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rd_drop: req=%b want 0", mem_req); end
      end
      for (int i = 0; i < 10 && D_OE !== 1'b1; i++) tick();
      checks++; if (D_OE !== 1'b1 || D_OUT !== exp) begin errs++; $display("FAIL rd_data @%h: D_OE=%b D_OUT=%h want 1/%h", addr, D_OE, D_OUT, exp); end
      if (boot) begin
         checks++; if (boot_addr !== addr[7:0]) begin errs++; $display("FAIL boot_addr: got %h want %h", boot_addr, addr[7:0]); end
      end
      tick(3);
      checks++; if (D_OE !== 1'b1 || D_OUT !== exp) begin errs++; $display("FAIL rd_hold: D_OE=%b D_OUT=%h want 1/%h", D_OE, D_OUT, exp); end
      RD = 1'b0; MREQ = 1'b0;
      for (int i = 0; i < 10 && D_OE !== 1'b0; i++) tick();
      checks++; if (D_OE !== 1'b0 || D_OUT !== exp) begin errs++; $display("FAIL rd_release: D_OE=%b D_OUT=%h want 0/%h", D_OE, D_OUT, exp); end
      checks++; if (req_cnt - r0 !== (boot ? 0 : 1)) begin errs++; $display("FAIL rd_reqcount: got %0d want %0d", req_cnt - r0, boot ? 0 : 1); end
   endtask

   task automatic test_write(input logic [15:0] addr, input logic [7:0] data, input int lat);
      int r0;
      r0 = req_cnt;
      A = addr; D_IN = data; WR = 1'b1;
      tick(4);
      WR = 1'b0; A = 16'($urandom); D_IN = 8'($urandom);
      tick();
      if (addr == 16'hFF50 && data != 8'h00) boot_m = 1'b0;
      for (int i = 0; i < 10 && mem_req !== 1'b1; i++) tick();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== addr || mem_wdata !== data) begin errs++; $display("FAIL wr_req: req=%b we=%b addr=%h wdata=%h want 1/1/%h/%h", mem_req, mem_we, mem_addr, mem_wdata, addr, data); end
      checks++; if (boot_en !== boot_m) begin errs++; $display("FAIL wr_boot_en: got %b want %b", boot_en, boot_m); end
      for (int i = 0; i < lat; i++) begin
         tick();
         checks++; if (mem_req !== 1'b1 || mem_addr !== addr || mem_wdata !== data) begin errs++; $display("FAIL wr_hold: req=%b addr=%h wdata=%h want 1/%h/%h", mem_req, mem_addr, mem_wdata, addr, data); end
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL wr_drop: req=%b want 0", mem_req); end
      tick();
      checks++; if (req_cnt - r0 !== 1) begin errs++; $display("FAIL wr_reqcount: got %0d want 1", req_cnt - r0); end
   endtask

   task automatic test_boot_exit();
      test_write(16'hFF50, 8'h00, 1);
      checks++; if (boot_en !== 1'b1) begin errs++; $display("FAIL boot_keep: boot_en=%b want 1", boot_en); end
      test_read(16'h0005, 0);
      test_write(16'hFF50, 8'h01, 2);
      checks++; if (boot_en !== 1'b0) begin errs++; $display("FAIL boot_exit: boot_en=%b want 0", boot_en); end
      test_read(16'h0005, 2);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 0)
            test_read($urandom_range(0, 1) == 0 ? 16'($urandom_range(0, 16'h01FF)) : 16'($urandom), $urandom_range(0, 5));
         else
            test_write($urandom_range(0, 5) == 0 ? 16'hFF50 : 16'($urandom), $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom), $urandom_range(0, 5));
      end
      checks++; if (overrun !== 1'b0) begin errs++; $display("FAIL rand_overrun: got %b want 0", overrun); end
   endtask

   task automatic test_overrun();
      int r0;
      do_reset();
      r0 = req_cnt;
      A = 16'h4000; MREQ = 1'b1; RD = 1'b1;
      for (int i = 0; i < 10 && mem_req !== 1'b1; i++) tick();
      WR = 1'b1; tick(3); WR = 1'b0; tick(5);
      checks++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_set: overrun=%b want 1", overrun); end
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h4000) begin errs++; $display("FAIL ovr_req: req=%b we=%b addr=%h want 1/0/4000", mem_req, mem_we, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 8'h5A; tick(); mem_ack = 1'b0;
      checks++; if (D_OE !== 1'b1 || D_OUT !== 8'h5A) begin errs++; $display("FAIL ovr_data: D_OE=%b D_OUT=%h want 1/5A", D_OE, D_OUT); end
      RD = 1'b0; MREQ = 1'b0;
      tick(8);
      checks++; if (D_OE !== 1'b0 || overrun !== 1'b1) begin errs++; $display("FAIL ovr_end: D_OE=%b overrun=%b want 0/1", D_OE, overrun); end
      checks++; if (req_cnt - r0 !== 1) begin errs++; $display("FAIL ovr_reqcount: got %0d want 1", req_cnt - r0); end
   endtask

   task automatic test_collide();
      int r0;
      do_reset();
      r0 = req_cnt;
      A = 16'h8123; D_IN = 8'h99; WR = 1'b1;
      tick(4);
      WR = 1'b0; RD = 1'b1; MREQ = 1'b1;
      for (int i = 0; i < 10 && mem_req !== 1'b1; i++) tick();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h8123 || mem_wdata !== 8'h99) begin errs++; $display("FAIL col_req: req=%b we=%b addr=%h wdata=%h want 1/1/8123/99", mem_req, mem_we, mem_addr, mem_wdata); end
      checks++; if (overrun !== 1'b1) begin errs++; $display("FAIL col_overrun: got %b want 1", overrun); end
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      tick(4);
      RD = 1'b0; MREQ = 1'b0;
      tick(4);
      checks++; if (req_cnt - r0 !== 1 || D_OE !== 1'b0) begin errs++; $display("FAIL col_end: reqs=%0d D_OE=%b want 1/0", req_cnt - r0, D_OE); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      A = 16'h0200; MREQ = 1'b1; RD = 1'b1;
      for (int i = 0; i < 10 && mem_req !== 1'b1; i++) tick();
      checks++; if (mem_req !== 1'b1) begin errs++; $display("FAIL mid_req: req=%b want 1", mem_req); end
      nRESET = 1'b0; RD = 1'b0; MREQ = 1'b0;
      tick();
      nRESET = 1'b1;
      checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0 || D_OE !== 1'b0 || boot_en !== 1'b1 || overrun !== 1'b0) begin errs++; $display("FAIL mid_reset: req=%b addr=%h D_OE=%b boot_en=%b overrun=%b want 0/0000/0/1/0", mem_req, mem_addr, D_OE, boot_en, overrun); end
      tick(2);
      mem_ack = 1'b1; mem_rdata = 8'hEE; tick(); mem_ack = 1'b0;
      tick(4);
      checks++; if (D_OE !== 1'b0 || mem_req !== 1'b0 || D_OUT !== 8'h00) begin errs++; $display("FAIL mid_late_ack: D_OE=%b req=%b D_OUT=%h want 0/0/00", D_OE, mem_req, D_OUT); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      test_reset();
      test_read(16'h0005, 0);
      test_read(16'h0150, 3);
      test_write(16'hC000, 8'h3C, 3);
      test_read(16'hFFFF, 1);
      test_boot_exit();
      do_reset();
      test_random();
      test_overrun();
      test_collide();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
